// File: rtl/rr_mux_ctrl_pkg.sv
// Shared constants and grant encoding for the round-robin 2:1 mux feeder.
// The round-robin step is a function so the arbiter and any checker use the same rule.
package rr_mux_pkg;

    localparam logic LANE_A = 1'b0;
    localparam logic LANE_B = 1'b1;
    localparam int   MUX_DW = 2;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    function automatic grant_e rr_next(input grant_e last);
        grant_e nxt;
        case (last)
            GRANT_A: nxt = GRANT_B;
            GRANT_B: nxt = GRANT_A;
            default: nxt = GRANT_A;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/rr_mux_ctrl_if.sv
// Lane inputs and mux-side outputs of rr_mux_ctrl.
// prio_B exists only when RR_MUX_CTRL_PRIO_EN is defined.
interface rr_mux_ctrl_if #(
    parameter int DW = 2
);

    logic          in_valid_A;
    logic [DW-1:0] in_data_A;
    logic          in_ready_A;
    logic          in_valid_B;
    logic [DW-1:0] in_data_B;
    logic          in_ready_B;
    logic [DW-1:0] data_A;
    logic [DW-1:0] data_B;
    logic          selector;
    logic          out_valid;
    logic          out_ready;
`ifdef RR_MUX_CTRL_PRIO_EN
    logic          prio_B;

    modport master (
        output in_valid_A, in_data_A, in_valid_B, in_data_B, out_ready, prio_B,
        input  in_ready_A, in_ready_B, data_A, data_B, selector, out_valid
    );

    modport slave (
        input  in_valid_A, in_data_A, in_valid_B, in_data_B, out_ready, prio_B,
        output in_ready_A, in_ready_B, data_A, data_B, selector, out_valid
    );
`else
    modport master (
        output in_valid_A, in_data_A, in_valid_B, in_data_B, out_ready,
        input  in_ready_A, in_ready_B, data_A, data_B, selector, out_valid
    );

    modport slave (
        input  in_valid_A, in_data_A, in_valid_B, in_data_B, out_ready,
        output in_ready_A, in_ready_B, data_A, data_B, selector, out_valid
    );
`endif

endinterface

// File: rtl/rr_mux_ctrl_lane_fifo.sv
// Per-lane circular FIFO. A push while full is dropped here, so the caller may
// leave push asserted. Head data is visible one edge after the push.
module lane_fifo #(
    parameter int DEPTH = 2,
    parameter int DW    = 2
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign head      = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/rr_mux_ctrl.sv
// Two-lane round-robin feeder for a 2-bit 2:1 mux; output registers advance only on load.
// Define RR_MUX_CTRL_PRIO_EN to add prio_B, which lets a non-empty lane B override the rotation.
module rr_mux_ctrl
    import rr_mux_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int DW    = MUX_DW
) (
    input logic          clk,
    input logic          reset_L,
    rr_mux_ctrl_if.slave bus
);

    logic [DW-1:0] head_a_s;
    logic [DW-1:0] head_b_s;
    logic          full_a_s;
    logic          full_b_s;
    logic          empty_a_s;
    logic          empty_b_s;
    logic          pop_a_s;
    logic          pop_b_s;
    logic          load_s;
    logic          grant_v_s;
    logic          prio_s;
    grant_e        grant_s;
    grant_e        last_grant_r;
    logic [DW-1:0] data_a_r;
    logic [DW-1:0] data_b_r;
    logic          selector_r;
    logic          out_valid_r;

`ifdef RR_MUX_CTRL_PRIO_EN
    assign prio_s = bus.prio_B;
`else
    assign prio_s = 1'b0;
`endif

    lane_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo_a (
        .clk     (clk),
        .reset_L (reset_L),
        .push    (bus.in_valid_A),
        .pop     (pop_a_s),
        .wr_data (bus.in_data_A),
        .head    (head_a_s),
        .full    (full_a_s),
        .empty   (empty_a_s)
    );

    lane_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo_b (
        .clk     (clk),
        .reset_L (reset_L),
        .push    (bus.in_valid_B),
        .pop     (pop_b_s),
        .wr_data (bus.in_data_B),
        .head    (head_b_s),
        .full    (full_b_s),
        .empty   (empty_b_s)
    );

    // Arbitration: decide which lane (if any) moves into the output register this edge.
    always_comb begin
        load_s    = !out_valid_r || bus.out_ready;
        grant_v_s = 1'b0;
        grant_s   = GRANT_A;
        if (!load_s) begin
            grant_v_s = 1'b0;
            grant_s   = GRANT_A;
        end else if (!empty_a_s && !empty_b_s) begin
            grant_v_s = 1'b1;
            if (prio_s) begin
                grant_s = GRANT_B;
            end else begin
                grant_s = rr_next(last_grant_r);
            end
        end else if (!empty_a_s) begin
            grant_v_s = 1'b1;
            grant_s   = GRANT_A;
        end else if (!empty_b_s) begin
            grant_v_s = 1'b1;
            grant_s   = GRANT_B;
        end else begin
            grant_v_s = 1'b0;
            grant_s   = GRANT_A;
        end
        pop_a_s = grant_v_s && (grant_s == GRANT_A);
        pop_b_s = grant_v_s && (grant_s == GRANT_B);
    end

    // Output register and grant history; everything is frozen while a transfer is stalled.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_a_r     <= {DW{1'b0}};
            data_b_r     <= {DW{1'b0}};
            selector_r   <= LANE_A;
            out_valid_r  <= 1'b0;
            last_grant_r <= GRANT_B;
        end else if (load_s) begin
            if (grant_v_s) begin
                case (grant_s)
                    GRANT_A: begin
                        data_a_r   <= head_a_s;
                        selector_r <= LANE_A;
                    end
                    GRANT_B: begin
                        data_b_r   <= head_b_s;
                        selector_r <= LANE_B;
                    end
                    default: begin
                        selector_r <= selector_r;
                    end
                endcase
                out_valid_r  <= 1'b1;
                last_grant_r <= grant_s;
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.in_ready_A = !full_a_s;
    assign bus.in_ready_B = !full_b_s;
    assign bus.data_A     = data_a_r;
    assign bus.data_B     = data_b_r;
    assign bus.selector   = selector_r;
    assign bus.out_valid  = out_valid_r;

endmodule

// File: tb/tb_rr_mux_ctrl.sv
// Self-checking bench for rr_mux_ctrl: a queue-based lane model feeds a transfer scoreboard
// and a per-cycle output comparison. Define RR_MUX_CTRL_PRIO_EN to exercise prio_B.
module tb_rr_mux_ctrl;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic reset_L;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [1:0] qa[$];
    logic [1:0] qb[$];
    logic [2:0] exp_q[$];
    logic       m_ov;
    logic       m_sel;
    logic [1:0] m_da;
    logic [1:0] m_db;
    logic       m_last;

    rr_mux_ctrl_if #(.DW(2)) bus_if ();

    rr_mux_ctrl #(.DEPTH(DEPTH), .DW(2)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        exp_q.delete();
        m_ov   = 1'b0;
        m_sel  = 1'b0;
        m_da   = 2'b00;
        m_db   = 2'b00;
        m_last = 1'b1;
    endtask

    // Called just after a rising edge, while the inputs that edge sampled are still applied.
    task automatic model_step();
        bit         load, ga, gb, acc_a, acc_b, pr;
        logic [1:0] d;
        pr = 1'b0;
`ifdef RR_MUX_CTRL_PRIO_EN
        pr = bus_if.prio_B;
`endif
        load  = !m_ov || bus_if.out_ready;
        acc_a = bus_if.in_valid_A && (qa.size() < DEPTH);
        acc_b = bus_if.in_valid_B && (qb.size() < DEPTH);
        ga = 1'b0;
        gb = 1'b0;
        if (load) begin
            if (qa.size() > 0 && qb.size() > 0) begin
                if (pr) gb = 1'b1;
                else if (m_last) ga = 1'b1;
                else gb = 1'b1;
            end else if (qa.size() > 0) begin
                ga = 1'b1;
            end else if (qb.size() > 0) begin
                gb = 1'b1;
            end
            if (ga) begin
                d = qa.pop_front();
                m_da = d; m_sel = 1'b0; m_ov = 1'b1; m_last = 1'b0;
                exp_q.push_back({1'b0, d});
            end else if (gb) begin
                d = qb.pop_front();
                m_db = d; m_sel = 1'b1; m_ov = 1'b1; m_last = 1'b1;
                exp_q.push_back({1'b1, d});
            end else begin
                m_ov = 1'b0;
            end
        end
        if (acc_a) qa.push_back(bus_if.in_data_A);
        if (acc_b) qb.push_back(bus_if.in_data_B);
    endtask

    task automatic cycle();
        logic [2:0] e;
        logic [1:0] mux_out;
        if (bus_if.out_valid && bus_if.out_ready) begin
            check_val("sb_pending", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                mux_out = bus_if.selector ? bus_if.data_B : bus_if.data_A;
                check_val("sb_sel", 32'(bus_if.selector), 32'(e[2]));
                check_val("sb_data", 32'(mux_out), 32'(e[1:0]));
            end
        end
        @(posedge clk);
        model_step();
        #1;
        check_val("out_valid", 32'(bus_if.out_valid), 32'(m_ov));
        check_val("selector", 32'(bus_if.selector), 32'(m_sel));
        check_val("data_A", 32'(bus_if.data_A), 32'(m_da));
        check_val("data_B", 32'(bus_if.data_B), 32'(m_db));
        check_val("in_ready_A", 32'(bus_if.in_ready_A), 32'(qa.size() < DEPTH));
        check_val("in_ready_B", 32'(bus_if.in_ready_B), 32'(qb.size() < DEPTH));
    endtask

    task automatic idle_inputs();
        bus_if.in_valid_A = 1'b0;
        bus_if.in_data_A  = 2'b00;
        bus_if.in_valid_B = 1'b0;
        bus_if.in_data_B  = 2'b00;
`ifdef RR_MUX_CTRL_PRIO_EN
        bus_if.prio_B = 1'b0;
`endif
    endtask

    task automatic drain(input int n);
        idle_inputs();
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        reset_L = 1'b0;
        idle_inputs();
        bus_if.out_ready = 1'b0;
        model_reset();
        #12;
        check_val("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check_val("rst_selector", 32'(bus_if.selector), 32'd0);
        check_val("rst_data_A", 32'(bus_if.data_A), 32'd0);
        check_val("rst_data_B", 32'(bus_if.data_B), 32'd0);
        check_val("rst_in_ready_A", 32'(bus_if.in_ready_A), 32'd1);
        reset_L = 1'b1;

        // Single push on A: visible one edge after the push.
        bus_if.out_ready  = 1'b1;
        bus_if.in_valid_A = 1'b1;
        bus_if.in_data_A  = 2'b10;
        cycle();
        idle_inputs();
        cycle();
        check_val("t1_out_valid", 32'(bus_if.out_valid), 32'd1);
        check_val("t1_selector", 32'(bus_if.selector), 32'd0);
        check_val("t1_data_A", 32'(bus_if.data_A), 32'd2);
        drain(3);

        // Both lanes fed every cycle.
        for (int i = 0; i < 8; i++) begin
            bus_if.in_valid_A = 1'b1;
            bus_if.in_data_A  = 2'((i + 1) & 3);
            bus_if.in_valid_B = 1'b1;
            bus_if.in_data_B  = 2'((i * 3) & 3);
            bus_if.out_ready  = 1'b1;
            cycle();
        end
        drain(8);

        // Stall with A pushing: 1 word in the output register plus 2 queued, then blocked.
        bus_if.out_ready  = 1'b0;
        bus_if.in_valid_A = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus_if.in_data_A = 2'(i);
            cycle();
        end
        check_val("t3_in_ready_A", 32'(bus_if.in_ready_A), 32'd0);
        bus_if.in_data_A = 2'b00;
        cycle();
        cycle();
        check_val("t3_frozen_valid", 32'(bus_if.out_valid), 32'd1);
        check_val("t3_frozen_data", 32'(bus_if.data_A), 32'd1);

        // Full A with push and pop on the same edge: push is blocked, count drops to 1.
        bus_if.out_ready = 1'b1;
        cycle();
        check_val("t4_in_ready_A", 32'(bus_if.in_ready_A), 32'd1);
        check_val("t4_data_A", 32'(bus_if.data_A), 32'd2);
        drain(5);

        // Reset asserted mid-stream while a transfer is held.
        for (int i = 0; i < 3; i++) begin
            bus_if.in_valid_A = 1'b1;
            bus_if.in_data_A  = 2'b11;
            bus_if.in_valid_B = 1'b1;
            bus_if.in_data_B  = 2'b11;
            bus_if.out_ready  = (i < 2) ? 1'b1 : 1'b0;
            cycle();
        end
        idle_inputs();
        #2;
        reset_L = 1'b0;
        #1;
        check_val("t5_out_valid", 32'(bus_if.out_valid), 32'd0);
        check_val("t5_selector", 32'(bus_if.selector), 32'd0);
        check_val("t5_data_A", 32'(bus_if.data_A), 32'd0);
        check_val("t5_data_B", 32'(bus_if.data_B), 32'd0);
        check_val("t5_in_ready_A", 32'(bus_if.in_ready_A), 32'd1);
        model_reset();
        @(negedge clk);
        reset_L = 1'b1;
        bus_if.in_valid_A = 1'b1;
        bus_if.in_data_A  = 2'b01;
        bus_if.in_valid_B = 1'b1;
        bus_if.in_data_B  = 2'b10;
        bus_if.out_ready  = 1'b1;
        cycle();
        idle_inputs();
        cycle();
        check_val("t5_first_grant", 32'(bus_if.selector), 32'd0);
        check_val("t5_first_valid", 32'(bus_if.out_valid), 32'd1);
        drain(4);

`ifdef RR_MUX_CTRL_PRIO_EN
        // Priority on B while both lanes are busy, then B stops feeding.
        for (int i = 0; i < 6; i++) begin
            bus_if.in_valid_A = 1'b1;
            bus_if.in_data_A  = 2'(i & 3);
            bus_if.in_valid_B = (i < 3) ? 1'b1 : 1'b0;
            bus_if.in_data_B  = 2'((i + 2) & 3);
            bus_if.prio_B     = 1'b1;
            bus_if.out_ready  = 1'b1;
            cycle();
        end
        drain(6);
`endif

        drain(2);
        check_val("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
